// File: rtl/input_conditioner.sv
// Three-channel synchroniser and debouncer with a qualified enable for the downstream logic stage.
// Optional macro COND_GLITCH_CNT_EN adds glitch_cnt_o, a saturating count of aborted (bounced) changes.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en_i,
    input  logic raw_a_i,
    input  logic raw_b_i,
    input  logic raw_c_i,
    output logic a_o,
    output logic b_o,
    output logic c_o,
    output logic en_o,
    output logic chg_o
`ifdef COND_GLITCH_CNT_EN
    ,
    output logic [7:0] glitch_cnt_o
`endif
);

    typedef enum logic {
        STABLE,
        SETTLING
    } state_e;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [2:0]       raw;
    logic [2:0]       s1;
    logic [2:0]       s2;
    logic [2:0]       dout;
    state_e           state [3];
    logic [CNT_W-1:0] cnt   [3];
    logic [2:0]       upd;
    logic [2:0]       abort;
    logic             all_stable;

    assign raw             = {raw_c_i, raw_b_i, raw_a_i};
    assign {c_o, b_o, a_o} = dout;

    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        upd        = '0;
        abort      = '0;
        all_stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (state[i] == SETTLING) begin
                all_stable = 1'b0;
                if (s2[i] == dout[i])
                    abort[i] = 1'b1;
                else if (cnt[i] == CNT_LAST)
                    upd[i] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1    <= '0;
            s2    <= '0;
            dout  <= '0;
            en_o  <= 1'b0;
            chg_o <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                state[i] <= STABLE;
                cnt[i]   <= '0;
            end
        end else begin
            s1    <= raw;
            s2    <= s1;
            chg_o <= |upd;
            // Rising needs all channels settled; once high, only en_i drops it.
            en_o  <= en_i & (en_o | all_stable);
            for (int i = 0; i < 3; i++) begin
                case (state[i])
                    STABLE: begin
                        if (s2[i] != dout[i]) begin
                            state[i] <= SETTLING;
                            cnt[i]   <= CNT_W'(1);
                        end else begin
                            cnt[i]   <= '0;
                        end
                    end
                    SETTLING: begin
                        if (abort[i]) begin
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else if (upd[i]) begin
                            dout[i]  <= s2[i];
                            state[i] <= STABLE;
                            cnt[i]   <= '0;
                        end else begin
                            cnt[i]   <= cnt[i] + CNT_W'(1);
                        end
                    end
                    default: begin
                        state[i] <= STABLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

`ifdef COND_GLITCH_CNT_EN
    logic [8:0] glitch_sum;

    assign glitch_sum = {1'b0, glitch_cnt_o} + 9'(abort[0]) + 9'(abort[1]) + 9'(abort[2]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            glitch_cnt_o <= '0;
        else
            glitch_cnt_o <= (glitch_sum > 9'd255) ? 8'hFF : glitch_sum[7:0];
    end
`endif

endmodule
